// File: rtl/uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// uart_rx_oversample
//
// UART receiver driven by a 16x-baud enable pulse. The serial line is
// synchronised, every bit is decided by a 3-sample majority vote around
// mid-bit, and start/stop/optional parity are checked. Completed words go
// to a one-entry valid/ready holding register. Words with errors are still
// delivered, with their flags set.
//
// Ports:
//   clk_50M     in   system clock
//   reset       in   synchronous, active-high
//   tick_16x    in   one-cycle enable at 16x baud
//   rx_serial   in   asynchronous serial line, idle high
//   rx_data     out  received word (DATA_BITS wide)
//   rx_valid    out  rx_data and error flags are valid
//   rx_ready    in   consumer accepts the word when rx_valid & rx_ready
//   frame_err   out  stop bit was sampled low
//   parity_err  out  parity mismatch
//   overrun     out  sticky: an unread word was overwritten
//   busy        out  receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk_50M,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
        return PARITY_EN & ((^d) ^ p ^ PARITY_ODD);
    endfunction

    // Input synchroniser; flops idle high so reset never looks like a start bit.
    logic sync1_q, sync2_q;
    logic rx_s;

    // Receiver control
    state_t     state_q;
    logic [3:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic       busy_q;

    // Receiver datapath
    logic                 s7_q, s8_q, bit_val_q, par_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 bit_val_now;
    logic                 frame_done;

    // Output holding register
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 accept;

    assign rx_s = sync2_q;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
        end
    end

    // Vote uses the live rx_s as the third sample, valid on the cnt=9 tick.
    assign bit_val_now = majority3(s7_q, s8_q, rx_s);
    // The stop bit completes at mid-bit so the next start edge is never missed.
    assign frame_done  = tick_16x && (state_q == S_STOP) && (cnt_q == 4'd9);

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            bit_idx_q <= 3'd0;
            busy_q    <= 1'b0;
        end else if (tick_16x) begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= 4'd0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        if (bit_val_q) begin
                            // Line went back high by mid-bit: noise, not a start bit.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_DATA;
                            bit_idx_q <= 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= PARITY_EN ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        cnt_q <= 4'd0;
                        if (bit_val_now) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line (break) must not be read as back-to-back starts.
                    cnt_q <= 4'd0;
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sample capture and shifting; no reset needed, control qualifies all use.
    always_ff @(posedge clk_50M) begin
        if (tick_16x) begin
            if (cnt_q == 4'd7) s7_q <= rx_s;
            if (cnt_q == 4'd8) s8_q <= rx_s;
            if (cnt_q == 4'd9) bit_val_q <= bit_val_now;
            if (state_q == S_DATA && cnt_q == 4'd15) begin
                shift_q <= {bit_val_q, shift_q[DATA_BITS-1:1]};
            end
            if (state_q == S_PARITY && cnt_q == 4'd15) begin
                par_q <= bit_val_q;
            end
        end
    end

    assign accept = rx_valid_q && rx_ready;

    // Handshake runs every cycle, independent of tick_16x.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (accept) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (frame_done) begin
            rx_data_d    = shift_q;
            frame_err_d  = ~bit_val_now;
            parity_err_d = parity_mismatch(shift_q, par_q);
            rx_valid_d   = 1'b1;
            // Only a word that is neither accepted now nor earlier is lost.
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_oversample
//
// Bench for uart_rx_oversample. Instance A is 8N1, instance B is 8E1. Both
// share the clock and a tick every 4 clocks (64 clocks per bit). Expected
// words are queued when a frame is sent and compared when the DUT hands
// the word over.
// ---------------------------------------------------------------------------
module tb_uart_rx_oversample;

    logic       clk_50M  = 1'b0;
    logic       reset    = 1'b1;
    logic       tick_16x = 1'b0;
    int         tdiv     = 0;

    logic       rx_a = 1'b1, ready_a = 1'b1;
    logic [7:0] data_a;
    logic       valid_a, fe_a, pe_a, ovr_a, busy_a;

    logic       rx_b = 1'b1, ready_b = 1'b1;
    logic [7:0] data_b;
    logic       valid_b, fe_b, pe_b, ovr_b, busy_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       ovr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    typedef struct {
        bit         sel;       // 0 = A (8N1), 1 = B (8E1)
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vt[8];

    uart_rx_oversample #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .tick_16x   (tick_16x),
        .rx_serial  (rx_a),
        .rx_data    (data_a),
        .rx_valid   (valid_a),
        .rx_ready   (ready_a),
        .frame_err  (fe_a),
        .parity_err (pe_a),
        .overrun    (ovr_a),
        .busy       (busy_a)
    );

    uart_rx_oversample #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .tick_16x   (tick_16x),
        .rx_serial  (rx_b),
        .rx_data    (data_b),
        .rx_valid   (valid_b),
        .rx_ready   (ready_b),
        .frame_err  (fe_b),
        .parity_err (pe_b),
        .overrun    (ovr_b),
        .busy       (busy_b)
    );

    always #10 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        tdiv     = (tdiv + 1) % 4;
        tick_16x = (tdiv == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: one pop per accepted word.
    always @(negedge clk_50M) begin
        if (!reset && valid_a && ready_a) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_word: got %02h expected none", data_a);
            end else begin
                ea = q_a.pop_front();
                chk("a_data", 32'(data_a), 32'(ea.data));
                chk("a_frame_err", 32'(fe_a), 32'(ea.fe));
                chk("a_parity_err", 32'(pe_a), 32'(ea.pe));
                chk("a_overrun", 32'(ovr_a), 32'(ea.ovr));
            end
        end
    end

    always @(negedge clk_50M) begin
        if (!reset && valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_word: got %02h expected none", data_b);
            end else begin
                eb = q_b.pop_front();
                chk("b_data", 32'(data_b), 32'(eb.data));
                chk("b_frame_err", 32'(fe_b), 32'(eb.fe));
                chk("b_parity_err", 32'(pe_b), 32'(eb.pe));
                chk("b_overrun", 32'(ovr_b), 32'(eb.ovr));
            end
        end
    end

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic line(input bit sel, input logic v, input int n);
        drive(sel, v);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic set_ready_a(input logic v);
        @(posedge clk_50M);
        #2 ready_a = v;
    endtask

    // Start the frame on the negedge right after a tick so sample points
    // are known: the cnt=7/8/9 votes of a bit see the line at 33.5/37.5/41.5
    // clocks into that bit.
    task automatic align_tick();
        @(posedge clk_50M);
        while (tick_16x !== 1'b1) @(posedge clk_50M);
        @(negedge clk_50M);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop, input int noise_slot);
        logic [10:0] bits;
        int          n;
        bits = '0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (has_par) begin
            bits[9] = par;
            n = 10;
        end
        bits[n] = stop;
        n = n + 1;
        align_tick();
        for (int s = 0; s < n; s++) begin
            if (s == noise_slot) begin
                line(sel, bits[s], 36);
                line(sel, ~bits[s], 4);
                line(sel, bits[s], 24);
            end else begin
                line(sel, bits[s], 64);
            end
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] d, input logic fe,
                        input logic pe, input logic ovr);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        e.ovr  = ovr;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    initial begin
        //              sel  data   par   stop  exp_data fe    pe
        vt[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[3] = '{1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
        vt[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vt[5] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
        vt[6] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vt[7] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1};

        reset = 1'b1;
        repeat (4) @(negedge clk_50M);
        reset = 1'b0;
        @(negedge clk_50M);
        chk("rst_data", 32'(data_a), 32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_flags", 32'({fe_a, pe_a, ovr_a}), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_valid_b", 32'(valid_b), 32'h0);

        // Table-driven frames, both formats.
        for (int i = 0; i < 8; i++) begin
            push(vt[i].sel, vt[i].exp_data, vt[i].exp_fe, vt[i].exp_pe, 1'b0);
            send_frame(vt[i].sel, vt[i].data, vt[i].sel, vt[i].par, vt[i].stop, -1);
            line(vt[i].sel, 1'b1, 32);
            chk($sformatf("vec%0d_busy_idle", i),
                32'(vt[i].sel ? busy_b : busy_a), 32'h0);
        end

        // Short low glitch: false start, then a clean frame.
        align_tick();
        line(1'b0, 1'b0, 20);
        line(1'b0, 1'b1, 10);
        chk("glitch_busy_high", 32'(busy_a), 32'h1);
        line(1'b0, 1'b1, 100);
        chk("glitch_busy_low", 32'(busy_a), 32'h0);
        push(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
        line(1'b0, 1'b1, 32);

        // One-sample noise on data bit 2 (slot 3) of 0x00.
        push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3);
        line(1'b0, 1'b1, 32);

        // Framing error followed by a 40-bit break.
        push(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
        line(1'b0, 1'b0, 40 * 64);
        chk("break_busy", 32'(busy_a), 32'h1);
        chk("break_no_valid", 32'(valid_a), 32'h0);
        line(1'b0, 1'b1, 64);
        chk("break_release", 32'(busy_a), 32'h0);
        push(1'b0, 8'h12, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
        line(1'b0, 1'b1, 32);

        // Overrun with the consumer stalled.
        set_ready_a(1'b0);
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
        line(1'b0, 1'b1, 32);
        chk("ovr_first_data", 32'(data_a), 32'h11);
        chk("ovr_first_valid", 32'(valid_a), 32'h1);
        chk("ovr_first_flag", 32'(ovr_a), 32'h0);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
        line(1'b0, 1'b1, 32);
        chk("ovr_second_data", 32'(data_a), 32'h22);
        chk("ovr_second_flag", 32'(ovr_a), 32'h1);
        push(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        set_ready_a(1'b1);
        repeat (3) @(negedge clk_50M);
        chk("ovr_cleared_valid", 32'(valid_a), 32'h0);
        chk("ovr_cleared_flag", 32'(ovr_a), 32'h0);

        // Reset mid-frame with a flagged word pending.
        set_ready_a(1'b0);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, -1);
        line(1'b0, 1'b1, 32);
        chk("pre_rst_data", 32'(data_a), 32'hC3);
        chk("pre_rst_fe", 32'(fe_a), 32'h1);
        align_tick();
        line(1'b0, 1'b0, 64);                  // start
        line(1'b0, 1'b1, 64);                  // bit0 of 0x81
        line(1'b0, 1'b0, 3 * 64);              // bits1..3
        line(1'b0, 1'b0, 32);                  // half of bit4
        chk("mid_frame_busy", 32'(busy_a), 32'h1);
        reset = 1'b1;
        repeat (2) @(negedge clk_50M);
        reset = 1'b0;
        rx_a  = 1'b1;
        chk("rst2_data", 32'(data_a), 32'h0);
        chk("rst2_valid", 32'(valid_a), 32'h0);
        chk("rst2_flags", 32'({fe_a, pe_a, ovr_a}), 32'h0);
        chk("rst2_busy", 32'(busy_a), 32'h0);
        set_ready_a(1'b1);
        line(1'b0, 1'b1, 64);
        push(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
        line(1'b0, 1'b1, 32);

        // Bounded drain of both scoreboards.
        for (int i = 0; i < 500 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(negedge clk_50M);
        end
        chk("sb_a_drained", 32'(q_a.size()), 32'h0);
        chk("sb_b_drained", 32'(q_b.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
UART receiver that consumes the 16x-oversample enable pulse produced by the baud-rate divider (its `clk_rx` output). It deserialises the asynchronous `rx_serial` line into DATA_BITS-wide words. Each bit is taken by 3-sample majority vote, and the block checks start, stop and optional parity. Words are presented to the downstream consumer through a one-entry valid/ready holding register.

Parameters:
DATA_BITS, 8, data bits per frame (5..8), sent LSB first
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0

Ports:
clk_50M  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high
tick_16x  input  1  one-clk_50M-cycle enable at 16x baud (divider clk_rx)
rx_serial  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word
rx_valid  output  1  rx_data/error flags valid
rx_ready  input  1  consumer accepts word when rx_valid & rx_ready
frame_err  output  1  stop bit sampled low; qualifies rx_data
parity_err  output  1  parity mismatch; qualifies rx_data
overrun  output  1  sticky: unread word was overwritten
busy  output  1  state != IDLE

Behaviour:
- Reset: clk_50M is the clock; reset is synchronous and active-high. All outputs reset to 0. State returns to IDLE; tick counter and bit index clear. Both synchroniser flops reset to 1. A frame in progress is abandoned.
- rx_serial passes through a 2-flop synchroniser, giving rx_s (2-cycle latency). All decisions use rx_s only.
- All state and counter updates happen only on cycles with tick_16x=1. With no tick, everything holds, except the handshake logic, which runs every cycle.
- Bit timing uses tick counter cnt (0..15). Within each bit, rx_s is captured on ticks with cnt=7 and cnt=8. On the cnt=9 tick, bit_val = majority(s7, s8, rx_s) is formed.
- States:
  - IDLE: on a tick with rx_s=0, go to START with cnt=0.
  - START: on cnt=15, if bit_val=1 it is a false start: return to IDLE with no flags. Otherwise go to DATA with bit_idx=0.
  - DATA: on cnt=15, shift bit_val into shift register LSB-first and increment bit_idx. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: on cnt=15, store bit_val as par_bit, then go to STOP.
  - STOP: on the cnt=9 tick, complete the frame. This is an early exit for resynchronisation. If bit_val=1, go to IDLE; else go to WAIT_HIGH.
  - WAIT_HIGH: on a tick with rx_s=1, go to IDLE. This blocks a break condition from being read as repeated start bits.
- cnt wraps 15->0 at each bit boundary; bit_idx is 3 bits wide.
- Frame completion (same cycle as the STOP cnt=9 tick):
  - rx_data <= shift register.
  - frame_err <= ~bit_val.
  - parity_err <= PARITY_EN & (XOR(data) ^ par_bit ^ PARITY_ODD).
  - rx_valid <= 1.
  - Frames with errors are still delivered, with the flags set.
- Handshake:
  - rx_valid & rx_ready: rx_valid clears on the next cycle, and overrun clears.
  - Completion while rx_valid=1 and rx_ready=0: new word and flags overwrite the old ones, and overrun is set.
  - Completion in the same cycle as an accept: the new word loads, rx_valid stays 1, and overrun is not set.
- frame_err and parity_err are updated only at frame completion; they are meaningful only while rx_valid=1.
- Minimum latency from the stop bit's cnt=9 tick to rx_valid high is 1 clk_50M cycle.

Test Plan:
- 8N1, tick every 4 clocks (64 clocks/bit), send 0xA5 with valid stop, rx_ready=1 -> one rx_valid pulse with rx_data=0xA5, frame_err=0, parity_err=0, overrun=0, busy falling back to 0.
- Glitch: rx_serial low for 5 ticks then high -> START aborts at cnt=15, no rx_valid, busy back to 0; a following 0x3C frame is received correctly.
- Single-tick noise: force rx_serial high during tick cnt=8 of data bit 2 of 0x00 -> majority still yields rx_data=0x00.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_err=0; send 0x07 with parity bit 0 -> parity_err=1, rx_valid=1.
- Framing/break: send 0x55 with stop bit 0, then hold line low 40 bit times -> one word, 0x55 with frame_err=1. No further rx_valid until the line returns high; the next 0x12 frame is received cleanly.
- Overrun/reset: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x22, overrun=1. Raise rx_ready -> rx_valid and overrun clear. Assert reset mid-frame (DATA bit 4) -> all outputs 0, busy=0, next frame 0x81 received correctly.
